// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use bubble insertion.
// Latency: one cycle from accept to alu_data*/alu_control; forwarding and hazard flag are combinational.
// Backpressure: in_ready drops on stall or load-use hazard; ID holds its instruction until accepted.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   in_valid / in_ready            ID handshake
//   stall / flush                  downstream hold / squash of EX contents
//   id_*                           decoded operands, register numbers, immediate and control
//   exmem_* / memwb_*              forwarding sources (EX/MEM has priority)
//   ex_valid, alu_*, ex_*          EX-side outputs to the ALU and EX/MEM register
//   load_use_hazard                combinational load-use detection
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [IMM_W-1:0] id_imm,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_sign_ext,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             ex_valid,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RA_W-1:0]  ex_wr_reg,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             load_use_hazard
);

  logic             valid_q;
  logic [RA_W-1:0]  rs_q;
  logic [RA_W-1:0]  rt_q;
  logic [RA_W-1:0]  wr_reg_q;
  logic [WIDTH-1:0] rs_data_q;
  logic [WIDTH-1:0] rt_data_q;
  logic [WIDTH-1:0] imm_ext_q;
  logic [3:0]       alu_ctrl_q;
  logic             alu_src_q;
  logic             reg_write_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic             mem_to_reg_q;

  logic [WIDTH-1:0] id_imm_ext;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;
  logic             load;

  // Extension happens at capture so EX only ever sees a WIDTH-wide immediate.
  assign id_imm_ext = id_sign_ext ? {{(WIDTH-IMM_W){id_imm[IMM_W-1]}}, id_imm}
                                  : {{(WIDTH-IMM_W){1'b0}}, id_imm};

  // Control outputs are gated so a bubble can never write architectural state.
  assign ex_valid      = valid_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;
  assign ex_mem_to_reg = valid_q & mem_to_reg_q;
  assign alu_control   = alu_ctrl_q;
  assign ex_wr_reg     = wr_reg_q;

  // rt only matters when it is an ALU operand or the store data source.
  assign load_use_hazard = ex_mem_read & in_valid & (wr_reg_q != '0) &
                           ((id_rs == wr_reg_q) |
                            ((id_rt == wr_reg_q) & (~id_alu_src | id_mem_write)));

  assign in_ready = ~stall & ~load_use_hazard;
  assign load     = in_valid & in_ready;

  // Youngest producer (EX/MEM) wins; register 0 is hard-wired and never forwarded.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && exmem_rd == rs_q && rs_q != '0) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && memwb_rd == rs_q && rs_q != '0) begin
      fwd_rs = memwb_result;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_reg_write && exmem_rd == rt_q && rt_q != '0) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && memwb_rd == rt_q && rt_q != '0) begin
      fwd_rt = memwb_result;
    end
  end

  assign alu_data1     = fwd_rs;
  assign alu_data2     = alu_src_q ? imm_ext_q : fwd_rt;
  assign ex_store_data = fwd_rt;

  // Priority: reset > flush > stall > (load | bubble). Flush overrides stall so a
  // squashed instruction cannot linger in EX while the pipe is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      wr_reg_q     <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_ext_q    <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        valid_q      <= 1'b1;
        rs_q         <= id_rs;
        rt_q         <= id_rt;
        wr_reg_q     <= id_reg_dst ? id_rd : id_rt;
        rs_data_q    <= id_rs_data;
        rt_data_q    <= id_rt_data;
        imm_ext_q    <= id_imm_ext;
        alu_ctrl_q   <= id_alu_ctrl;
        alu_src_q    <= id_alu_src;
        reg_write_q  <= id_reg_write;
        mem_read_q   <= id_mem_read;
        mem_write_q  <= id_mem_write;
        mem_to_reg_q <= id_mem_to_reg;
      end else begin
        // Hazard or idle: insert a bubble, datapath fields are don't-care.
        valid_q      <= 1'b0;
        reg_write_q  <= 1'b0;
        mem_read_q   <= 1'b0;
        mem_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
      end
    end
  end

endmodule
